// File: rtl/al_pkg.sv
// Shared definitions for the alarm-clock keypad entry path: FSM encodings,
// PS/2 keypad scancodes and the scancode-to-BCD decoder.
package al_pkg;

  typedef enum logic [3:0] {
    ST_SHOW_TIME     = 4'd0,
    ST_KEY_STORE     = 4'd1,
    ST_KEY_HOLD      = 4'd2,
    ST_KEY_RELEASE   = 4'd3,
    ST_ENTRY         = 4'd4,
    ST_COMMIT_ALARM  = 4'd5,
    ST_COMMIT_TIME   = 4'd6,
    ST_SHOW_ALARM    = 4'd7,
    ST_ALARM_RELEASE = 4'd8,
    ST_SLOT_NEXT     = 4'd9,
    ST_ERROR         = 4'd10
  } state_t;

  localparam logic [7:0] KP_0            = 8'h70;
  localparam logic [7:0] KP_1            = 8'h69;
  localparam logic [7:0] KP_2            = 8'h72;
  localparam logic [7:0] KP_3            = 8'h7A;
  localparam logic [7:0] KP_4            = 8'h6B;
  localparam logic [7:0] KP_5            = 8'h73;
  localparam logic [7:0] KP_6            = 8'h74;
  localparam logic [7:0] KP_7            = 8'h6C;
  localparam logic [7:0] KP_8            = 8'h75;
  localparam logic [7:0] KP_9            = 8'h7D;
  localparam logic [7:0] KP_STAR         = 8'h7C;
  localparam logic [7:0] KP_MINUS        = 8'h7B;
  localparam logic [7:0] KP_PLUS         = 8'h79;
  localparam logic [7:0] KP_PERIOD       = 8'h71;
  localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
  localparam logic [7:0] KP_INVALID      = 8'hFF;

  typedef struct packed {
    logic       vld;
    logic [3:0] val;
  } bcd_t;

  function automatic bcd_t bcd_digit(input logic [7:0] k);
    bcd_t r;
    r.vld = 1'b1;
    case (k)
      KP_0: r.val = 4'd0;
      KP_1: r.val = 4'd1;
      KP_2: r.val = 4'd2;
      KP_3: r.val = 4'd3;
      KP_4: r.val = 4'd4;
      KP_5: r.val = 4'd5;
      KP_6: r.val = 4'd6;
      KP_7: r.val = 4'd7;
      KP_8: r.val = 4'd8;
      KP_9: r.val = 4'd9;
      default: begin
        r.vld = 1'b0;
        r.val = 4'd0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/al_bcd_time_check.sv
// Combinational HHMM validator: 00:00..23:59, every nibble a decimal digit.
module al_bcd_time_check (
  input  logic [15:0] hhmm_i,
  output logic        valid_o
);
  logic [3:0] ht, hu, mt, mu;

  assign {ht, hu, mt, mu} = hhmm_i;

  assign valid_o = (ht <= 4'd2) && (hu <= 4'd9) && (mt <= 4'd5) && (mu <= 4'd9) &&
                   !((ht == 4'd2) && (hu > 4'd3));
endmodule

// File: rtl/al_entry_controller.sv
// Keypad entry controller: collects BCD digits from keypad scancodes and commits
// them as the new time or into an alarm slot, with backspace, timeout and validation.
module al_entry_controller
  import al_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int NUM_ALARMS = 2,
  parameter int TIMEOUT_S  = 10,
  parameter int CHECK_TIME = 1,
  localparam int SLOT_W    = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int CW        = $clog2(DIGITS + 1),
  localparam int BW        = 4 * DIGITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              one_second,
  input  logic [7:0]        key,
  output logic [BW-1:0]     key_buffer,
  output logic [CW-1:0]     digit_count,
  output logic [SLOT_W-1:0] alarm_slot,
  output logic              load_alarm,
  output logic              load_new_time,
  output logic              show_alarm,
  output logic              show_keyboard,
  output logic              entry_error,
  output logic [3:0]        debug_state
);
  localparam logic [CW-1:0]     CNT_MAX  = CW'(DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(NUM_ALARMS - 1);
  localparam logic [7:0]        TMO      = 8'(TIMEOUT_S);

  state_t            state_q, state_d;
  logic [BW-1:0]     buf_q, buf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              ld_alarm_q, ld_alarm_d;
  logic              ld_time_q, ld_time_d;
  bcd_t              kd;
  logic              time_ok, commit_ok;

  assign kd = bcd_digit(key);

  generate
    if (CHECK_TIME != 0) begin : g_chk
      al_bcd_time_check u_chk (.hhmm_i(buf_q[15:0]), .valid_o(time_ok));
    end else begin : g_nochk
      assign time_ok = 1'b1;
    end
  endgenerate

  assign commit_ok = (cnt_q != '0) && time_ok;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    tmo_d      = tmo_q;
    ld_alarm_d = 1'b0;
    ld_time_d  = 1'b0;
    case (state_q)
      ST_SHOW_TIME: begin
        if (kd.vld) begin
          state_d = ST_KEY_STORE;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (key == KP_STAR) state_d = ST_SHOW_ALARM;
        else if (key == KP_PLUS)     state_d = ST_SLOT_NEXT;
      end
      ST_KEY_STORE: begin
        if (kd.vld) begin
          buf_d = {buf_q[BW-5:0], kd.val};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else if (key == KP_PERIOD) begin
          buf_d = {4'd0, buf_q[BW-1:4]};
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
        state_d = ST_KEY_HOLD;
      end
      ST_KEY_HOLD:
        if (key == KP_KEY_RELEASED) state_d = ST_KEY_RELEASE;
      ST_KEY_RELEASE:
        if (key == KP_INVALID) begin
          state_d = ST_ENTRY;
          tmo_d   = TMO;
        end
      ST_ENTRY: begin
        if (one_second && tmo_q != 8'd0) tmo_d = tmo_q - 8'd1;
        // Expiry outranks any key arriving in the same cycle
        if (tmo_q == 8'd0) begin
          state_d = ST_SHOW_TIME;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (key == KP_STAR)                state_d = ST_COMMIT_ALARM;
        else if (key == KP_MINUS)                   state_d = ST_COMMIT_TIME;
        else if (kd.vld || key == KP_PERIOD)        state_d = ST_KEY_STORE;
      end
      ST_COMMIT_ALARM: begin
        ld_alarm_d = commit_ok;
        state_d    = commit_ok ? ST_SHOW_TIME : ST_ERROR;
      end
      ST_COMMIT_TIME: begin
        ld_time_d = commit_ok;
        state_d   = commit_ok ? ST_SHOW_TIME : ST_ERROR;
      end
      ST_ERROR: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = ST_SHOW_TIME;
      end
      ST_SHOW_ALARM:
        if (key == KP_KEY_RELEASED) state_d = ST_ALARM_RELEASE;
        else if (key == KP_INVALID) state_d = ST_SHOW_TIME;
      ST_ALARM_RELEASE:
        if (key == KP_INVALID) state_d = ST_SHOW_TIME;
      ST_SLOT_NEXT: begin
        slot_d  = (slot_q == SLOT_MAX) ? '0 : slot_q + 1'b1;
        state_d = ST_ALARM_RELEASE;
      end
      default: state_d = ST_SHOW_TIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_SHOW_TIME;
      buf_q      <= '0;
      cnt_q      <= '0;
      slot_q     <= '0;
      tmo_q      <= 8'd0;
      ld_alarm_q <= 1'b0;
      ld_time_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      tmo_q      <= tmo_d;
      ld_alarm_q <= ld_alarm_d;
      ld_time_q  <= ld_time_d;
    end
  end

  // Load pulses are registered so the buffer they carry is already stable
  assign load_alarm    = ld_alarm_q;
  assign load_new_time = ld_time_q;
  assign entry_error   = (state_q == ST_ERROR);
  assign show_alarm    = (state_q == ST_SHOW_ALARM) || (state_q == ST_SLOT_NEXT);
  assign show_keyboard = ((state_q >= ST_KEY_STORE) && (state_q <= ST_COMMIT_TIME)) ||
                         (state_q == ST_ALARM_RELEASE);
  assign key_buffer    = buf_q;
  assign digit_count   = cnt_q;
  assign alarm_slot    = slot_q;
  assign debug_state   = state_q;
endmodule

// File: tb/tb_al_entry_controller.sv
// Directed bench for al_entry_controller with default parameters.
module tb_al_entry_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        one_second = 1'b0;
  logic [7:0]  key = 8'hFF;
  logic [15:0] key_buffer;
  logic [2:0]  digit_count;
  logic [0:0]  alarm_slot;
  logic        load_alarm, load_new_time, show_alarm, show_keyboard, entry_error;
  logic [3:0]  debug_state;

  int total = 0;
  int bad   = 0;
  int n_la  = 0;
  int n_lt  = 0;
  int n_err = 0;

  logic [7:0] kp [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  al_entry_controller dut (
    .clk(clk), .reset(reset), .one_second(one_second), .key(key),
    .key_buffer(key_buffer), .digit_count(digit_count), .alarm_slot(alarm_slot),
    .load_alarm(load_alarm), .load_new_time(load_new_time), .show_alarm(show_alarm),
    .show_keyboard(show_keyboard), .entry_error(entry_error), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_alarm)    n_la++;
    if (load_new_time) n_lt++;
    if (entry_error)   n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hold a key for n clock edges, returning 1 time unit after the last edge
  task automatic drive(input logic [7:0] k, input int n);
    key = k;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    drive(k, 2);
    drive(8'hF0, 2);
    drive(8'hFF, 2);
  endtask

  task automatic digit(input int d);
    press(kp[d]);
  endtask

  task automatic tick();
    one_second = 1'b1;
    @(posedge clk); #1;
    one_second = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", debug_state, 4'd0);
    chk("rst_buf", key_buffer, 16'h0000);
    chk("rst_cnt", digit_count, 3'd0);
    chk("rst_slot", alarm_slot, 1'b0);
    chk("rst_pulses", {load_alarm, load_new_time, entry_error}, 3'b000);
    chk("rst_show", {show_alarm, show_keyboard}, 2'b00);
    reset = 1'b1;
    drive(8'hFF, 2);

    // Set time 12:34
    digit(1); digit(2); digit(3); digit(4);
    chk("t_buf", key_buffer, 16'h1234);
    chk("t_cnt", digit_count, 3'd4);
    chk("t_entry", debug_state, 4'd4);
    chk("t_showkb", show_keyboard, 1'b1);
    drive(8'h7B, 1);
    chk("t_commit_st", debug_state, 4'd6);
    chk("t_early", load_new_time, 1'b0);
    drive(8'h7B, 1);
    chk("t_pulse", load_new_time, 1'b1);
    chk("t_back", debug_state, 4'd0);
    chk("t_pbuf", key_buffer, 16'h1234);
    drive(8'hF0, 1);
    chk("t_width", load_new_time, 1'b0);
    drive(8'hFF, 2);
    chk("t_nlt", n_lt, 1);

    // Next slot, then alarm 07:30 into slot 1
    press(8'h79);
    chk("s_slot", alarm_slot, 1'b1);
    chk("s_state", debug_state, 4'd0);
    digit(0); digit(7); digit(3); digit(0);
    drive(8'h7C, 2);
    chk("a_pulse", load_alarm, 1'b1);
    chk("a_buf", key_buffer, 16'h0730);
    chk("a_slot", alarm_slot, 1'b1);
    drive(8'hF0, 2); drive(8'hFF, 2);
    chk("a_nla", n_la, 1);

    // 25:00 rejected
    digit(2); digit(5); digit(0); digit(0);
    drive(8'h7C, 2);
    chk("e_err", entry_error, 1'b1);
    chk("e_noload", load_alarm, 1'b0);
    drive(8'hF0, 2); drive(8'hFF, 2);
    chk("e_buf", key_buffer, 16'h0000);
    chk("e_cnt", digit_count, 3'd0);
    chk("e_nerr", n_err, 1);
    chk("e_nla", n_la, 1);

    // Backspace and overflow
    digit(1); digit(2); digit(3);
    press(8'h71);
    chk("b_buf", key_buffer, 16'h0012);
    chk("b_cnt", digit_count, 3'd2);
    digit(4); digit(5); digit(6); digit(7); digit(8); digit(9);
    chk("o_buf", key_buffer, 16'h6789);
    chk("o_cnt", digit_count, 3'd4);
    press(8'h7B);
    chk("o_nerr", n_err, 2);
    chk("o_nlt", n_lt, 1);
    chk("o_clr", key_buffer, 16'h0000);

    // Empty entry after backspace is rejected even though 0000 is a valid time
    digit(5);
    press(8'h71);
    chk("z_cnt", digit_count, 3'd0);
    press(8'h7B);
    chk("z_nerr", n_err, 3);
    chk("z_nlt", n_lt, 1);

    // Timeout with reload
    digit(1);
    repeat (9) tick();
    chk("to_alive", debug_state, 4'd4);
    digit(2);
    chk("to_buf", key_buffer, 16'h0012);
    repeat (9) tick();
    chk("to_reload", debug_state, 4'd4);
    tick();
    chk("to_exp", debug_state, 4'd0);
    chk("to_buf0", key_buffer, 16'h0000);
    chk("to_cnt0", digit_count, 3'd0);
    chk("to_nopulse", n_la + n_lt + n_err, 32'd5);

    // Alarm display while star held
    drive(8'h7C, 2);
    chk("sa_state", debug_state, 4'd7);
    chk("sa_show", {show_alarm, show_keyboard}, 2'b10);
    drive(8'hFF, 1);
    chk("sa_back", debug_state, 4'd0);

    // Reset in KEY_HOLD with three digits
    digit(1); digit(2);
    drive(kp[3], 2);
    chk("r_hold", debug_state, 4'd2);
    chk("r_cnt3", digit_count, 3'd3);
    key = 8'hFF;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("r_state", debug_state, 4'd0);
    chk("r_buf", key_buffer, 16'h0000);
    chk("r_cnt", digit_count, 3'd0);
    chk("r_slot", alarm_slot, 1'b0);
    chk("r_outs", {load_alarm, load_new_time, entry_error, show_alarm, show_keyboard}, 5'd0);
    press(8'h7B);
    chk("r_noload", n_lt, 1);
    chk("r_idle", debug_state, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/al_entry_controller.md
# al_entry_controller

Parametrised keypad entry controller for the alarm clock. It turns PS/2 keypad scancodes into a BCD entry buffer of DIGITS digits, then commits that buffer as the new current time or into one of NUM_ALARMS alarm slots. It adds entry validation, a backspace key, a configurable inactivity timeout and alarm-slot selection. It sits between the keyboard scancode receiver and the time/alarm registers and display mux.

## Interface
- DIGITS, 4: BCD digits in the entry buffer (≥2).
- NUM_ALARMS, 2: alarm slots (≥1); SLOT_W = max(1, $clog2(NUM_ALARMS)).
- TIMEOUT_S, 10: seconds of inactivity before an entry is abandoned (1..255).
- CHECK_TIME, 1: when 1 (requires DIGITS=4), commit requires HH ≤ 23 and MM ≤ 59.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset: 0 = reset, sampled on rising clk.
- one_second  in  1  one-clk strobe once per second.
- key  in  8  current scancode; KP_INVALID (8'hFF) when idle.
- key_buffer  out  4*DIGITS  BCD entry, newest digit in [3:0].
- digit_count  out  $clog2(DIGITS+1)  digits entered, saturating at DIGITS.
- alarm_slot  out  SLOT_W  selected slot.
- load_alarm  out  1  one-clk pulse; alarm register alarm_slot loads key_buffer.
- load_new_time  out  1  one-clk pulse; time counter loads key_buffer.
- show_alarm  out  1  display the alarm of alarm_slot.
- show_keyboard  out  1  display key_buffer.
- entry_error  out  1  one-clk pulse on a rejected commit.
- debug_state  out  4  current state encoding.

## Operation
- Keycodes come from keycodes.vh: KP_0..KP_9 (70,69,72,7A,6B,73,74,6C,75,7D), KP_STAR 7C, KP_MINUS 7B, KP_PLUS 79, KP_PERIOD 71, KP_KEY_RELEASED F0, KP_INVALID FF.
- States: SHOW_TIME(0), KEY_STORE(1), KEY_HOLD(2), KEY_RELEASE(3), ENTRY(4), COMMIT_ALARM(5), COMMIT_TIME(6), SHOW_ALARM(7), ALARM_RELEASE(8), SLOT_NEXT(9), ERROR(10).
- SHOW_TIME
  - Digit → KEY_STORE. Buffer and count are cleared first, then the digit is stored.
  - KP_STAR → SHOW_ALARM.
  - KP_PLUS → SLOT_NEXT.
  - Any other key: stay.
- KEY_STORE (1 clk)
  - Digit: shift the buffer left 4, insert the BCD digit, count+1 saturating. Digits shifted out of the top are lost.
  - KP_PERIOD (backspace): shift right 4, zero-fill the top, count−1 floored at 0.
  - Always → KEY_HOLD.
- KEY_HOLD: on F0 → KEY_RELEASE.
- KEY_RELEASE: on FF → ENTRY; load the timeout counter with TIMEOUT_S.
- ENTRY
  - Priority order: timeout==0 → SHOW_TIME with buffer cleared.
  - Then KP_STAR → COMMIT_ALARM.
  - Then KP_MINUS → COMMIT_TIME.
  - Then digit or KP_PERIOD → KEY_STORE.
- COMMIT_ALARM / COMMIT_TIME (1 clk)
  - The commit is rejected if count==0, or if CHECK_TIME=1 and the buffer is not a valid HHMM time (hour tens >2, HH >23, minute tens >5, or any nibble >9).
  - Valid: pulse load_alarm or load_new_time → SHOW_TIME.
  - Invalid: → ERROR.
- ERROR (1 clk): pulse entry_error, clear the buffer, → SHOW_TIME.
- SHOW_ALARM: show_alarm=1 while the key is held; F0 → ALARM_RELEASE; FF → SHOW_TIME.
- SLOT_NEXT: alarm_slot increments, wrapping NUM_ALARMS−1 → 0, on entry; → ALARM_RELEASE (shared release path).
- show_keyboard=1 in states 1–6 and 8. show_alarm=1 in 7 and 9.
- An unused state encoding → SHOW_TIME.

## Timing
- Moore FSM: outputs decode curr_state, so they change one clk after the causing key is sampled.
- The commit pulse asserts 2 clk after KP_STAR or KP_MINUS is sampled in ENTRY, and is exactly 1 clk wide.
- Timeout counter
  - Decrements only in ENTRY, on one_second, while >0.
  - Reaches SHOW_TIME one clk after it hits 0.
  - A one_second in the same clk as a key load gives priority to the load.
  - A key and timeout==0 in the same clk: timeout wins.
- Reset (reset=0 at a clk edge) forces SHOW_TIME with buffer=0, count=0, alarm_slot=0, timeout=0. All pulses are 0 and show_* are 0. A reset mid-entry discards the entry and must not emit a load pulse.

## Structure
- Shared package al_pkg.vh:
  - the state encodings;
  - the KP_* keycodes, re-exported from keycodes.vh;
  - a function bcd_digit(key) → 4-bit value, with valid bit.
- One sub-module: al_bcd_time_check (combinational HHMM validator), so the alarm/time registers can reuse it.

## Test plan
- Key sequence 69,F0,FF,72,F0,FF,7A,F0,FF,6B,F0,FF,7B with CHECK_TIME=1 → key_buffer 16'h1234, one load_new_time pulse 2 clk after 7B, then SHOW_TIME.
- Key 79, F0, FF, then digits 0,7,3,0, then 7C → alarm_slot=1, load_alarm with buffer 16'h0730.
- Digits 2,5,0,0 then 7C → entry_error pulse, no load_alarm, buffer 0.
- Digits 1,2,3 then 71 (backspace) → buffer 16'h0012, count 2. Then six digits on DIGITS=4 → only the last four are retained, count=4.
- Key 69 then no key for TIMEOUT_S one_second strobes → SHOW_TIME, buffer 0, no pulses; an extra digit before expiry reloads TIMEOUT_S.
- Reset=0 asserted for one clk while in KEY_HOLD with three digits entered → all outputs at reset values the next clk, and a subsequent 7B produces no load.
